axis_width_downsizer: RTL

- Downstream stage placed directly after the AXI-Stream FIFO. Consumes its wide beats (data, keep, last) and re-emits them as a narrower AXI-Stream.
- Each input beat is split into RATIO = IN_WIDTH/OUT_WIDTH output lanes, least-significant lane first.
- Lanes whose keep bits are all zero are skipped. tlast is moved onto the final emitted lane.
- Typical use: 32-bit FIFO output feeding an 8-bit byte-serial consumer.

---
 rtl/axis_width_downsizer_pkg.sv | 28 ++
 rtl/axis_width_downsizer_lane_pick.sv | 35 +++
 rtl/axis_width_downsizer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/axis_width_downsizer_pkg.sv
// Shared helpers for the AXI-Stream width conversion blocks: lane sizing,
// one-hot detection and parameter legality.
package axis_pkg;

  localparam int unsigned AXIS_BYTE_W   = 8;
  localparam int unsigned AXIS_MASK_MAX = 64;

  function automatic int unsigned lane_count(input int unsigned in_w,
                                             input int unsigned out_w);
    return (out_w == 0) ? 0 : in_w / out_w;
  endfunction

  // True when exactly one bit of the mask is set.
  function automatic logic onehot_check(input logic [AXIS_MASK_MAX-1:0] mask);
    return (mask != '0) && ((mask & (mask - 64'd1)) == '0);
  endfunction

  function automatic logic widths_ok(input int unsigned in_w,
                                     input int unsigned out_w);
    return (out_w != 0) &&
           (in_w % out_w == 0) &&
           (out_w % AXIS_BYTE_W == 0) &&
           (in_w % AXIS_BYTE_W == 0) &&
           (in_w / out_w >= 2) &&
           (in_w / out_w <= AXIS_MASK_MAX);
  endfunction

endpackage

// File: rtl/axis_width_downsizer_lane_pick.sv
// Combinational lane selector: lowest pending lane, single-lane-left flag and
// any-pending flag for a lane mask.
module axis_lane_pick
  import axis_pkg::*;
#(
  parameter int unsigned RATIO = 4,
  localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic [RATIO-1:0] mask_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             is_last_o,
  output logic             any_o
);

  logic [AXIS_MASK_MAX-1:0] mask_ext;

  always_comb begin
    mask_ext              = '0;
    mask_ext[RATIO-1:0]   = mask_i;
  end

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    idx_o = '0;
    for (int unsigned i = RATIO; i > 0; i--) begin
      if (mask_i[i-1]) begin
        idx_o = IDX_W'(i - 1);
      end
    end
  end

  assign is_last_o = onehot_check(mask_ext);
  assign any_o     = |mask_i;

endmodule

// File: rtl/axis_width_downsizer.sv
// Splits each wide AXI-Stream beat into narrow lanes, LSB lane first, skipping
// lanes with no kept bytes and moving tlast onto the final emitted lane.
module axis_width_downsizer
  import axis_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 8
) (
  input  logic                   aclk,
  input  logic                   areset_n,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tvalid,
  input  logic [IN_WIDTH-1:0]    s_axis_tdata,
  input  logic [IN_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic                   s_axis_tlast,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tvalid,
  output logic [OUT_WIDTH-1:0]   m_axis_tdata,
  output logic [OUT_WIDTH/8-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast
);

  localparam int unsigned RATIO    = lane_count(IN_WIDTH, OUT_WIDTH);
  localparam int unsigned KEEP_IN  = IN_WIDTH / 8;
  localparam int unsigned KEEP_OUT = OUT_WIDTH / 8;
  localparam int unsigned IDX_W    = (RATIO > 1) ? $clog2(RATIO) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  if (!widths_ok(IN_WIDTH, OUT_WIDTH)) begin : g_bad_widths
    $error("axis_width_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH, OUT_WIDTH a multiple of 8, ratio >= 2");
  end

  logic [IN_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [KEEP_IN-1:0]  hold_keep_q, hold_keep_d;
  logic                hold_last_q, hold_last_d;
  logic [RATIO-1:0]    lane_pend_q, lane_pend_d;
  logic                rdy_en_q;

  logic [IDX_W-1:0]     cur_idx;
  logic                 one_left;
  logic                 any_pend;
  logic [0:0]           state;
  logic [RATIO-1:0]     in_mask;
  logic [RATIO-1:0]     load_mask;
  logic [OUT_WIDTH-1:0] lane_data [RATIO];
  logic [KEEP_OUT-1:0]  lane_keep [RATIO];
  logic                 m_fire;
  logic                 s_fire;

  axis_lane_pick #(
    .RATIO (RATIO)
  ) u_lane_pick (
    .mask_i    (lane_pend_q),
    .idx_o     (cur_idx),
    .is_last_o (one_left),
    .any_o     (any_pend)
  );

  assign state = any_pend ? ST_SEND : ST_IDLE;

  always_comb begin
    for (int unsigned i = 0; i < RATIO; i++) begin
      lane_data[i] = hold_data_q[i*OUT_WIDTH +: OUT_WIDTH];
      lane_keep[i] = hold_keep_q[i*KEEP_OUT +: KEEP_OUT];
      in_mask[i]   = |s_axis_tkeep[i*KEEP_OUT +: KEEP_OUT];
    end
  end

  // An all-null beat carrying tlast still emits lane 0 so the boundary survives.
  always_comb begin
    load_mask = in_mask;
    if ((in_mask == '0) && s_axis_tlast) begin
      load_mask = RATIO'(1);
    end
  end

  assign m_axis_tvalid = (state == ST_SEND);
  assign m_axis_tdata  = lane_data[cur_idx];
  assign m_axis_tkeep  = lane_keep[cur_idx];
  assign m_axis_tlast  = hold_last_q & one_left;

  assign s_axis_tready = rdy_en_q & ((state == ST_IDLE) | (one_left & m_axis_tready));

  assign m_fire = m_axis_tvalid & m_axis_tready;
  assign s_fire = s_axis_tvalid & s_axis_tready;

  always_comb begin
    hold_data_d = hold_data_q;
    hold_keep_d = hold_keep_q;
    hold_last_d = hold_last_q;
    lane_pend_d = lane_pend_q;
    if (m_fire) begin
      lane_pend_d[cur_idx] = 1'b0;
    end
    // Acceptance only happens with at most the final lane in flight, so the
    // reload safely overrides that lane's clear.
    if (s_fire) begin
      hold_data_d = s_axis_tdata;
      hold_keep_d = s_axis_tkeep;
      hold_last_d = s_axis_tlast;
      lane_pend_d = load_mask;
    end
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      hold_data_q <= '0;
      hold_keep_q <= '0;
      hold_last_q <= 1'b0;
      lane_pend_q <= '0;
      rdy_en_q    <= 1'b0;
    end else begin
      hold_data_q <= hold_data_d;
      hold_keep_q <= hold_keep_d;
      hold_last_q <= hold_last_d;
      lane_pend_q <= lane_pend_d;
      rdy_en_q    <= 1'b1;
    end
  end

endmodule
